// File: rtl/mem_stage_sequencer_pkg.sv
// mem_stage_sequencer_pkg: shared state encoding and default widths for the memory stage sequencer
package mem_stage_sequencer_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_REG_ADDR_WIDTH = 4;
  localparam int DEF_TIMEOUT_CYCLES = 15;
  localparam int DEF_CNT_WIDTH = 4;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
endpackage

// File: rtl/mem_stage_sequencer_if.sv
// mem_stage_sequencer_if: data-memory request/response bus between the memory stage and data memory
interface mem_stage_sequencer_if import mem_stage_sequencer_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();
  logic mem_req;
  logic mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic mem_ready;
  modport master(output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
  modport slave(input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/mem_wait_counter.sv
// mem_wait_counter: memory wait-cycle counter with clear, enable and terminal-count flag
module mem_wait_counter import mem_stage_sequencer_pkg::*; #(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [CNT_WIDTH-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (!reset || clr) ? '0 : en ? cnt + 1'b1 : cnt;
  always_comb tc = cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/mem_stage_sequencer.sv
// mem_stage_sequencer: issues data-memory accesses, stalls the pipeline until done, registers write-back
module mem_stage_sequencer import mem_stage_sequencer_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic [DATA_WIDTH-1:0] result_in,
  input  logic [REG_ADDR_WIDTH-1:0] reg_addr_in,
  input  logic [ADDR_WIDTH-1:0] mem_addr_in,
  input  logic write_enable_in,
  input  logic store_enable_in,
  input  logic load_enable_in,
  mem_stage_sequencer_if.master mem,
  output logic stall_out,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic [REG_ADDR_WIDTH-1:0] wb_reg_addr,
  output logic wb_write_enable,
  output logic timeout_err
);
  state_t state, state_nxt;
  logic access, tc, lat_we;
  logic [REG_ADDR_WIDTH-1:0] lat_reg_addr;
  always_comb access = load_enable_in | store_enable_in;
  mem_wait_counter #(.CNT_WIDTH(CNT_WIDTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_cnt (
    .clk(clk),
    .reset(reset),
    .clr(state != WAIT),
    .en(state == WAIT && !mem.mem_ready),
    .tc(tc)
  );
  always_ff @(posedge clk)
    state <= !reset ? IDLE : state_nxt;
  always_comb
    state_nxt = state == IDLE ? (access ? WAIT : IDLE) :
                state == WAIT ? ((mem.mem_ready || tc) ? DONE : WAIT) : IDLE;
  always_comb stall_out = (state == IDLE && access) || state == WAIT;
  always_ff @(posedge clk)
    if (!reset) begin
      mem.mem_req <= 1'b0;
      mem.mem_we <= 1'b0;
      mem.mem_addr <= '0;
      mem.mem_wdata <= '0;
      lat_reg_addr <= '0;
      lat_we <= 1'b0;
      wb_data <= '0;
      wb_reg_addr <= '0;
      wb_write_enable <= 1'b0;
      timeout_err <= 1'b0;
    end else if (state == IDLE) begin
      if (access) begin
        mem.mem_req <= 1'b1;
        mem.mem_we <= store_enable_in;
        mem.mem_addr <= mem_addr_in;
        mem.mem_wdata <= result_in;
        lat_reg_addr <= reg_addr_in;
        lat_we <= write_enable_in;
        wb_write_enable <= 1'b0;
      end else begin
        wb_data <= result_in;
        wb_reg_addr <= reg_addr_in;
        wb_write_enable <= write_enable_in;
      end
    end else if (state == WAIT) begin
      if (mem.mem_ready) begin
        mem.mem_req <= 1'b0;
        wb_write_enable <= lat_we & ~mem.mem_we;
        if (!mem.mem_we) begin
          wb_data <= mem.mem_rdata;
          wb_reg_addr <= lat_reg_addr;
        end
      end else if (tc) begin
        mem.mem_req <= 1'b0;
        timeout_err <= 1'b1;
        wb_write_enable <= 1'b0;
      end
    end else
      wb_write_enable <= 1'b0;
endmodule

// File: tb/tb_mem_stage_sequencer.sv
// tb_mem_stage_sequencer: scoreboard bench for the memory stage sequencer
module tb_mem_stage_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [15:0] result_in = '0;
  logic [3:0] reg_addr_in = '0;
  logic [3:0] mem_addr_in = '0;
  logic write_enable_in = 1'b0;
  logic store_enable_in = 1'b0;
  logic load_enable_in = 1'b0;
  logic stall_out, wb_write_enable, timeout_err;
  logic [15:0] wb_data;
  logic [3:0] wb_reg_addr;
  logic prev_req = 1'b0;
  logic [19:0] wb_q[$];
  logic [20:0] mem_q[$];
  int errs = 0;
  int checks = 0;
  always #5 clk = ~clk;
  mem_stage_sequencer_if mif();
  mem_stage_sequencer dut (
    .clk(clk),
    .reset(reset),
    .result_in(result_in),
    .reg_addr_in(reg_addr_in),
    .mem_addr_in(mem_addr_in),
    .write_enable_in(write_enable_in),
    .store_enable_in(store_enable_in),
    .load_enable_in(load_enable_in),
    .mem(mif),
    .stall_out(stall_out),
    .wb_data(wb_data),
    .wb_reg_addr(wb_reg_addr),
    .wb_write_enable(wb_write_enable),
    .timeout_err(timeout_err)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in;
    load_enable_in = 1'b0;
    store_enable_in = 1'b0;
    write_enable_in = 1'b0;
    result_in = '0;
    reg_addr_in = '0;
    mem_addr_in = '0;
  endtask
  always @(negedge clk) begin
    logic [19:0] ew;
    logic [20:0] em;
    if (wb_write_enable) begin
      if (wb_q.size() == 0) chk("wb_unexpected", 32'({wb_data, wb_reg_addr}), 32'hFFFF_FFFF);
      else begin
        ew = wb_q.pop_front();
        chk("wb_strobe", 32'({wb_data, wb_reg_addr}), 32'(ew));
      end
    end
    if (mif.mem_req && !prev_req) begin
      if (mem_q.size() == 0) chk("mem_unexpected", 32'({mif.mem_we, mif.mem_addr, mif.mem_wdata}), 32'hFFFF_FFFF);
      else begin
        em = mem_q.pop_front();
        chk("mem_req", 32'({mif.mem_we, mif.mem_addr, mif.mem_wdata}), 32'(em));
      end
    end
    prev_req = mif.mem_req;
  end
  initial begin
    int n;
    mif.mem_ready = 1'b0;
    mif.mem_rdata = '0;
    tick;
    tick;
    chk("rst_mem_req", 32'(mif.mem_req), 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_wb_we", 32'(wb_write_enable), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    chk("rst_wb_data", 32'(wb_data), 32'd0);
    reset = 1'b1;
    result_in = 16'h00AB;
    reg_addr_in = 4'hA;
    write_enable_in = 1'b1;
    wb_q.push_back({16'h00AB, 4'hA});
    #1 chk("alu_stall", 32'(stall_out), 32'd0);
    tick;
    result_in = 16'h5555;
    reg_addr_in = 4'h3;
    wb_q.push_back({16'h5555, 4'h3});
    tick;
    idle_in;
    tick;
    load_enable_in = 1'b1;
    mem_addr_in = 4'hE;
    reg_addr_in = 4'h5;
    write_enable_in = 1'b1;
    mem_q.push_back({1'b0, 4'hE, 16'h0000});
    wb_q.push_back({16'h1234, 4'h5});
    #1 chk("ld_stall_idle", 32'(stall_out), 32'd1);
    tick;
    idle_in;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ld_req_held", 32'(mif.mem_req), 32'd1);
      chk("ld_addr_held", 32'(mif.mem_addr), 32'hE);
      chk("ld_stall_wait", 32'(stall_out), 32'd1);
      tick;
    end
    mif.mem_ready = 1'b1;
    mif.mem_rdata = 16'h1234;
    tick;
    mif.mem_ready = 1'b0;
    mif.mem_rdata = '0;
    #1;
    chk("ld_done_stall", 32'(stall_out), 32'd0);
    chk("ld_done_req", 32'(mif.mem_req), 32'd0);
    tick;
    chk("ld_strobe_end", 32'(wb_write_enable), 32'd0);
    store_enable_in = 1'b1;
    result_in = 16'h00FF;
    mem_addr_in = 4'h6;
    reg_addr_in = 4'h2;
    mem_q.push_back({1'b1, 4'h6, 16'h00FF});
    tick;
    idle_in;
    #1 chk("st_mem_we", 32'(mif.mem_we), 32'd1);
    tick;
    mif.mem_ready = 1'b1;
    mif.mem_rdata = 16'h9999;
    tick;
    mif.mem_ready = 1'b0;
    chk("st_no_wb", 32'(wb_write_enable), 32'd0);
    tick;
    load_enable_in = 1'b1;
    store_enable_in = 1'b1;
    result_in = 16'h0A0A;
    mem_addr_in = 4'h3;
    reg_addr_in = 4'h7;
    write_enable_in = 1'b1;
    mem_q.push_back({1'b1, 4'h3, 16'h0A0A});
    tick;
    idle_in;
    mif.mem_ready = 1'b1;
    mif.mem_rdata = 16'h7777;
    tick;
    mif.mem_ready = 1'b0;
    chk("ldst_no_wb", 32'(wb_write_enable), 32'd0);
    tick;
    result_in = 16'h0042;
    reg_addr_in = 4'h1;
    write_enable_in = 1'b1;
    mif.mem_ready = 1'b1;
    mif.mem_rdata = 16'hBEEF;
    wb_q.push_back({16'h0042, 4'h1});
    tick;
    mif.mem_ready = 1'b0;
    idle_in;
    #1;
    chk("idle_ready_req", 32'(mif.mem_req), 32'd0);
    chk("idle_ready_stall", 32'(stall_out), 32'd0);
    tick;
    load_enable_in = 1'b1;
    mem_addr_in = 4'h9;
    reg_addr_in = 4'h4;
    write_enable_in = 1'b1;
    mem_q.push_back({1'b0, 4'h9, 16'h0000});
    tick;
    idle_in;
    n = 0;
    for (int i = 0; i < 40 && mif.mem_req; i++) begin
      n++;
      tick;
    end
    chk("to_wait_cycles", 32'(n), 32'd15);
    chk("to_err", 32'(timeout_err), 32'd1);
    chk("to_no_wb", 32'(wb_write_enable), 32'd0);
    tick;
    result_in = 16'h0077;
    reg_addr_in = 4'hB;
    write_enable_in = 1'b1;
    wb_q.push_back({16'h0077, 4'hB});
    tick;
    idle_in;
    chk("to_sticky", 32'(timeout_err), 32'd1);
    tick;
    load_enable_in = 1'b1;
    mem_addr_in = 4'h1;
    reg_addr_in = 4'h6;
    write_enable_in = 1'b1;
    mem_q.push_back({1'b0, 4'h1, 16'h0000});
    tick;
    idle_in;
    tick;
    chk("rw_req_before", 32'(mif.mem_req), 32'd1);
    reset = 1'b0;
    tick;
    #1;
    chk("rw_req", 32'(mif.mem_req), 32'd0);
    chk("rw_stall", 32'(stall_out), 32'd0);
    chk("rw_timeout", 32'(timeout_err), 32'd0);
    chk("rw_wb_we", 32'(wb_write_enable), 32'd0);
    reset = 1'b1;
    tick;
    tick;
    chk("rw_idle_req", 32'(mif.mem_req), 32'd0);
    tick;
    chk("wb_q_empty", 32'(wb_q.size()), 32'd0);
    chk("mem_q_empty", 32'(mem_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
